// File: rtl/gcm_session_ctrl.sv
// AES-GCM board session sequencer: captures switch settings, streams NUM_BLOCKS plaintext
// blocks into the core, buffers ciphertext and tag, and pages the results to the display.
module gcm_session_ctrl #(
    parameter int unsigned NUM_BLOCKS  = 4,
    parameter int unsigned DISP_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [15:0]       i_sw,
    input  logic              i_start,
    input  logic              i_page_next,
    output logic              o_core_new,
    output logic [95:0]       o_core_iv,
    output logic [127:0]      o_core_key,
    output logic [127:0]      o_core_aad,
    output logic [127:0]      o_core_pt,
    output logic              o_core_pt_valid,
    input  logic              i_core_pt_ready,
    input  logic [127:0]      i_core_ct,
    input  logic              i_core_ct_valid,
    input  logic [127:0]      i_core_tag,
    input  logic              i_core_tag_valid,
    output logic [DISP_W-1:0] o_disp,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int unsigned    TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]     NB  = 5'(NUM_BLOCKS);
    localparam logic [TCW-1:0] TC  = TCW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        StIdle, StCapture, StLaunch, StRun, StWaitTag, StShow, StError
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        iv_q, iv_d;
    logic [3:0]        key_q, key_d, nib_q, nib_d, aad_q, aad_d;
    logic [4:0]        feed_q, feed_d, ct_idx_q, ct_idx_d, page_q, page_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic [DISP_W-1:0] buf_q [NUM_BLOCKS];
    logic [DISP_W-1:0] buf_d [NUM_BLOCKS];
    logic [DISP_W-1:0] tag_q, tag_d;
    logic [2:0]        start_sync_q, page_sync_q;
    logic              start_ev_q, page_ev_q;
    logic              pt_xfer, ct_xfer;
    logic              unused_core_bits;

    // Bits [0:DISP_W-1] of the core words are the MSB-first top slice.
    assign unused_core_bits = ^{i_core_ct, i_core_tag};

    assign o_core_new      = (state_q == StLaunch);
    assign o_core_pt_valid = (state_q == StRun) && (feed_q < NB);
    assign o_busy          = (state_q == StCapture) || (state_q == StLaunch) ||
                             (state_q == StRun) || (state_q == StWaitTag);
    assign o_done          = (state_q == StShow);
    assign o_err           = (state_q == StError);
    assign o_core_iv       = {12{iv_q}};
    assign o_core_key      = {32{key_q}};
    assign o_core_aad      = {32{aad_q}};
    assign o_core_pt       = {32{nib_q ^ feed_q[3:0]}};

    assign pt_xfer = o_core_pt_valid && i_core_pt_ready;
    assign ct_xfer = (state_q == StRun) && i_core_ct_valid && (ct_idx_q < NB);

    always_comb begin
        state_d  = state_q;
        iv_d     = iv_q;
        key_d    = key_q;
        nib_d    = nib_q;
        aad_d    = aad_q;
        feed_d   = feed_q;
        ct_idx_d = ct_idx_q;
        page_d   = page_q;
        tcnt_d   = tcnt_q;
        tag_d    = tag_q;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            buf_d[i] = (ct_xfer && (ct_idx_q == 5'(i))) ? i_core_ct[127 -: DISP_W] : buf_q[i];
        end

        unique case (state_q)
            StIdle, StError: begin
                if (start_ev_q) state_d = StCapture;
            end
            StCapture: begin
                iv_d     = i_sw[15:8];
                nib_d    = i_sw[7:4];
                key_d    = i_sw[3:0];
                aad_d    = ~i_sw[7:4];
                feed_d   = '0;
                ct_idx_d = '0;
                page_d   = '0;
                tcnt_d   = '0;
                state_d  = StLaunch;
            end
            StLaunch: state_d = StRun;
            StRun: begin
                if (pt_xfer) feed_d = feed_q + 5'd1;
                if (ct_xfer) ct_idx_d = ct_idx_q + 5'd1;
                tcnt_d = (pt_xfer || ct_xfer) ? '0 : tcnt_q + TCW'(1);
                // Exit on next-state indices so a tag right after the last block is caught.
                if (i_core_tag_valid && (ct_idx_q < NB)) state_d = StError;
                else if ((feed_d == NB) && (ct_idx_d == NB)) state_d = StWaitTag;
                else if (tcnt_d == TC) state_d = StError;
            end
            StWaitTag: begin
                if (i_core_tag_valid) begin
                    tag_d   = i_core_tag[127 -: DISP_W];
                    tcnt_d  = '0;
                    state_d = StShow;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                    if (tcnt_d == TC) state_d = StError;
                end
            end
            StShow: begin
                if (start_ev_q) state_d = StCapture;
                else if (page_ev_q) page_d = (page_q == NB) ? 5'd0 : page_q + 5'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_disp = '0;
        if (state_q == StShow) begin
            if (page_q == NB) begin
                o_disp = tag_q;
            end else begin
                for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                    if (page_q == 5'(i)) o_disp = buf_q[i];
                end
            end
        end else if (state_q == StError) begin
            o_disp = '1;
        end
    end

    // Two synchroniser flops, a history flop, then a registered rising-edge event.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            start_sync_q <= '0;
            page_sync_q  <= '0;
            start_ev_q   <= 1'b0;
            page_ev_q    <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], i_start};
            page_sync_q  <= {page_sync_q[1:0], i_page_next};
            start_ev_q   <= start_sync_q[1] & ~start_sync_q[2];
            page_ev_q    <= page_sync_q[1] & ~page_sync_q[2];
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            iv_q     <= '0;
            key_q    <= '0;
            nib_q    <= '0;
            aad_q    <= '0;
            feed_q   <= '0;
            ct_idx_q <= '0;
            page_q   <= '0;
            tcnt_q   <= '0;
            tag_q    <= '0;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            iv_q     <= iv_d;
            key_q    <= key_d;
            nib_q    <= nib_d;
            aad_q    <= aad_d;
            feed_q   <= feed_d;
            ct_idx_q <= ct_idx_d;
            page_q   <= page_d;
            tcnt_q   <= tcnt_d;
            tag_q    <= tag_d;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: tb/tb_gcm_session_ctrl.sv
// Bench for gcm_session_ctrl: directed sessions with a scoreboard of core-side expectations
// checked by a forked monitor, plus direct status and display checks.
module tb_gcm_session_ctrl;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic [15:0]  i_sw;
    logic         i_start, i_page_next;
    logic         o_core_new;
    logic [95:0]  o_core_iv;
    logic [127:0] o_core_key, o_core_aad, o_core_pt;
    logic         o_core_pt_valid, i_core_pt_ready;
    logic [127:0] i_core_ct, i_core_tag;
    logic         i_core_ct_valid, i_core_tag_valid;
    logic [15:0]  o_disp;
    logic         o_busy, o_done, o_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [95:0]  iv;
        logic [127:0] key;
        logic [127:0] aad;
        logic [127:0] pt;
    } cfg_t;

    cfg_t         cfg_q[$];
    logic [127:0] pt_q[$];

    gcm_session_ctrl #(
        .NUM_BLOCKS (NB),
        .DISP_W     (16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk             (clk),
        .i_reset_n       (i_reset_n),
        .i_sw            (i_sw),
        .i_start         (i_start),
        .i_page_next     (i_page_next),
        .o_core_new      (o_core_new),
        .o_core_iv       (o_core_iv),
        .o_core_key      (o_core_key),
        .o_core_aad      (o_core_aad),
        .o_core_pt       (o_core_pt),
        .o_core_pt_valid (o_core_pt_valid),
        .i_core_pt_ready (i_core_pt_ready),
        .i_core_ct       (i_core_ct),
        .i_core_ct_valid (i_core_ct_valid),
        .i_core_tag      (i_core_tag),
        .i_core_tag_valid(i_core_tag_valid),
        .o_disp          (o_disp),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no expected event, required event within bound", name);
    endtask

    task automatic monitor();
        bit   prev_wait = 1'b0;
        cfg_t c;
        forever begin
            @(negedge clk);
            if (!i_reset_n) begin
                prev_wait = 1'b0;
            end else begin
                if (o_core_new) begin
                    if (cfg_q.size() == 0) begin
                        fail_now("core_new_unexpected");
                    end else begin
                        c = cfg_q.pop_front();
                        check("core_iv", 128'(o_core_iv), 128'(c.iv));
                        check("core_key", o_core_key, c.key);
                        check("core_aad", o_core_aad, c.aad);
                        check("core_pt0", o_core_pt, c.pt);
                    end
                end
                if (prev_wait && o_busy) check("valid_hold", 128'(o_core_pt_valid), 128'(1));
                if (o_core_pt_valid && i_core_pt_ready) begin
                    if (pt_q.size() == 0) fail_now("pt_unexpected");
                    else check("pt_block", o_core_pt, pt_q.pop_front());
                end
                prev_wait = o_core_pt_valid && !i_core_pt_ready;
            end
        end
    endtask

    task automatic push_cfg(input logic [7:0] ivb, input logic [3:0] keyn, input logic [3:0] ptn);
        cfg_t c;
        c.iv  = {12{ivb}};
        c.key = {32{keyn}};
        c.aad = ~{32{ptn}};
        c.pt  = {32{ptn}};
        cfg_q.push_back(c);
    endtask

    task automatic wait_new(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = o_core_new;
        end
    endtask

    task automatic press_start(input bit chk);
        @(posedge clk); #1;
        i_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (chk) check("start_latency_n2", 128'(o_busy), 128'(0));
        @(posedge clk); #1;
        if (chk) check("start_latency_n3", 128'(o_busy), 128'(1));
        i_start = 1'b0;
    endtask

    task automatic page_press();
        @(posedge clk); #1;
        i_page_next = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_page_next = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // fin: 0 normal tag, 1 early tag after `stop` blocks, 2 stall after `stop` blocks
    task automatic run_core(input logic [7:0] ivb, input logic [3:0] keyn, input logic [3:0] ptn,
                            input bit bp, input int stop, input int fin, input bit extra,
                            input bit swchg, input bit strun);
        int fed = 0;
        int got = 0;
        int cyc = 0;
        bit xfer;
        bit seen;
        push_cfg(ivb, keyn, ptn);
        for (int k = 0; k < stop; k++) pt_q.push_back({32{ptn ^ 4'(k)}});
        wait_new(seen);
        if (!seen) begin
            fail_now("core_new_wait");
            return;
        end
        @(posedge clk); #1;
        if (swchg) i_sw = 16'hFFFF;
        if (strun) i_start = 1'b1;
        i_core_pt_ready = 1'b1;
        while (got < stop && cyc < 60) begin
            @(negedge clk);
            xfer = o_core_pt_valid && i_core_pt_ready;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) i_start = 1'b0;
            i_core_ct_valid = 1'b0;
            if (xfer) begin
                i_core_ct_valid = 1'b1;
                i_core_ct       = {32{4'(got)}};
                got++;
                fed++;
            end
            i_core_pt_ready = (bp ? (cyc % 3 == 0) : 1'b1) && (fed < stop);
        end
        if (got < stop) begin
            fail_now("ct_progress");
            i_core_ct_valid = 1'b0;
            i_core_pt_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_core_ct_valid = 1'b0;
        if (fin == 0) begin
            if (extra) begin
                i_core_ct_valid = 1'b1;
                i_core_ct       = {32{4'hE}};
                @(posedge clk); #1;
                i_core_ct_valid = 1'b0;
            end
            i_core_tag       = {32{4'h5}};
            i_core_tag_valid = 1'b1;
            @(posedge clk); #1;
            i_core_tag_valid = 1'b0;
            check("done_after_tag", 128'(o_done), 128'(1));
            check("disp_page0", 128'(o_disp), 128'(16'h0000));
        end else if (fin == 1) begin
            i_core_tag       = {32{4'h5}};
            i_core_tag_valid = 1'b1;
            @(posedge clk); #1;
            i_core_tag_valid = 1'b0;
            check("early_tag_err", 128'(o_err), 128'(1));
            check("early_tag_disp", 128'(o_disp), 128'(16'hFFFF));
            check("early_tag_busy", 128'(o_busy), 128'(0));
        end else begin
            repeat (7) @(posedge clk);
            #1;
            check("timeout_not_yet", 128'(o_err), 128'(0));
            @(posedge clk); #1;
            check("timeout_err", 128'(o_err), 128'(1));
            check("timeout_disp", 128'(o_disp), 128'(16'hFFFF));
        end
    endtask

    logic [15:0] exp_pages [5];
    bit          seen_new;

    initial begin
        exp_pages        = '{16'h1111, 16'h2222, 16'h3333, 16'h5555, 16'h0000};
        i_reset_n        = 1'b0;
        i_sw             = '0;
        i_start          = 1'b0;
        i_page_next      = 1'b0;
        i_core_pt_ready  = 1'b0;
        i_core_ct        = '0;
        i_core_ct_valid  = 1'b0;
        i_core_tag       = '0;
        i_core_tag_valid = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_status", 128'({o_busy, o_done, o_err, o_core_new, o_core_pt_valid}), 128'(0));
        check("reset_disp", 128'(o_disp), 128'(0));
        check("reset_aad", o_core_aad, 128'(0));
        i_reset_n = 1'b1;

        // Nominal session with one surplus ciphertext strobe, then a full page walk.
        i_sw = 16'hA53C;
        press_start(1'b1);
        run_core(8'hA5, 4'hC, 4'h3, 1'b0, NB, 0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            page_press();
            check("page_walk", 128'(o_disp), 128'(exp_pages[p]));
        end
        check("done_in_show", 128'(o_done), 128'(1));

        // Backpressure, switches moved and start pressed mid-session.
        i_sw = 16'h1E7B;
        press_start(1'b0);
        run_core(8'h1E, 4'hB, 4'h7, 1'b1, NB, 0, 1'b0, 1'b1, 1'b1);
        page_press();
        check("bp_page1", 128'(o_disp), 128'(16'h1111));

        // Early tag, then recovery.
        i_sw = 16'hA53C;
        press_start(1'b0);
        run_core(8'hA5, 4'hC, 4'h3, 1'b0, 2, 1, 1'b0, 1'b0, 1'b0);
        press_start(1'b0);
        run_core(8'hA5, 4'hC, 4'h3, 1'b0, NB, 0, 1'b0, 1'b0, 1'b0);

        // Stalled core, then recovery.
        press_start(1'b0);
        run_core(8'hA5, 4'hC, 4'h3, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0);
        press_start(1'b0);
        run_core(8'hA5, 4'hC, 4'h3, 1'b1, NB, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) page_press();
        check("recov_page3", 128'(o_disp), 128'(16'h3333));

        // Asynchronous reset in the middle of RUN.
        i_sw            = 16'h5A96;
        i_core_pt_ready = 1'b0;
        push_cfg(8'h5A, 4'h6, 4'h9);
        press_start(1'b0);
        wait_new(seen_new);
        if (!seen_new) fail_now("rst_core_new_wait");
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", 128'(o_core_pt_valid), 128'(1));
        i_reset_n = 1'b0;
        #1;
        check("rst_status", 128'({o_busy, o_done, o_err, o_core_new, o_core_pt_valid}), 128'(0));
        check("rst_iv_key", {o_core_iv, o_core_key[31:0]}, 128'(0));
        check("rst_pt", o_core_pt, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        i_sw      = 16'hA53C;
        press_start(1'b0);
        run_core(8'hA5, 4'hC, 4'h3, 1'b0, NB, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) page_press();
        check("post_rst_tag", 128'(o_disp), 128'(16'h5555));

        check("cfg_queue_drained", 128'(cfg_q.size()), 128'(0));
        check("pt_queue_drained", 128'(pt_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcm_session_ctrl.md
# gcm_session_ctrl

Board-level session sequencer for AES-GCM and the parametrised successor of the single-block board top. It captures the slide-switch settings into IV, key and plaintext seed registers. It then runs one GCM instance over `NUM_BLOCKS` plaintext blocks through a valid/ready core interface, buffers the ciphertext and the tag, and presents them page by page to the seven-segment display driver. It sits between the switch/button inputs, the `gcm_aes` core and the display module.

## Interface
- `NUM_BLOCKS`, 4: plaintext blocks per session; range 1..16.
- `DISP_W`, 16: width of the displayed word; range 8..128.
- `TIMEOUT_CYC`, 1024: idle cycles without a core transfer before error; must be ≥ 2.
- `clk`  in  1  system clock.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_sw`  in  16  switches: [0:7] IV byte, [8:11] plaintext nibble, [12:15] key nibble.
- `i_start`  in  1  start button, asynchronous level.
- `i_page_next`  in  1  page-advance button, asynchronous level.
- `o_core_new`  out  1  one-cycle pulse that starts a new GCM instance.
- `o_core_iv`  out  96  IV: captured byte replicated 12 times.
- `o_core_key`  out  128  key: captured nibble replicated 32 times.
- `o_core_aad`  out  128  AAD: bitwise inverse of the block-0 plaintext.
- `o_core_pt`  out  128  plaintext for the current feed index k: {32{nib ^ k[3:0]}}.
- `o_core_pt_valid`  out  1  plaintext valid.
- `i_core_pt_ready`  in  1  core accepts plaintext.
- `i_core_ct`  in  128  ciphertext block.
- `i_core_ct_valid`  in  1  one-cycle ciphertext strobe; blocks arrive in order.
- `i_core_tag`  in  128  tag.
- `i_core_tag_valid`  in  1  one-cycle tag strobe.
- `o_disp`  out  DISP_W  word to display.
- `o_busy`  out  1  session in progress.
- `o_done`  out  1  results valid.
- `o_err`  out  1  session aborted.

## Operation
- Buttons: each goes through a 2-flop synchroniser plus an edge register. Only a rising edge counts as an event.
- FSM states: IDLE, CAPTURE, LAUNCH, RUN, WAIT_TAG, SHOW, ERROR.
- IDLE: start event → CAPTURE.
- CAPTURE (1 cycle): registers `i_sw`. Core data outputs come only from these registers, so switch changes mid-session have no effect. Clears feed_idx, ct_idx, the timeout counter and the page counter. Next state is LAUNCH.
- LAUNCH (1 cycle): `o_core_new`=1. Next state is RUN.
- RUN: `o_core_pt_valid`=1 while feed_idx < NUM_BLOCKS. A transfer occurs when valid and `i_core_pt_ready` are both high, and feed_idx then increments.
- RUN, ciphertext: each `i_core_ct_valid` with ct_idx < NUM_BLOCKS stores `i_core_ct[0:DISP_W-1]` into buffer[ct_idx] and increments ct_idx. Strobes with ct_idx = NUM_BLOCKS are ignored.
- RUN exit: when both indices reach NUM_BLOCKS → WAIT_TAG. Feed and collect progress independently, and both may happen in the same cycle.
- RUN, early tag: `i_core_tag_valid` while ct_idx < NUM_BLOCKS → ERROR.
- WAIT_TAG: a tag strobe stores `i_core_tag[0:DISP_W-1]` into the tag register → SHOW.
- Timeout: in RUN and WAIT_TAG a counter increments each cycle and clears on any pt, ct or tag transfer. Reaching TIMEOUT_CYC → ERROR.
- SHOW:
  - Page counter runs 0..NUM_BLOCKS.
  - Pages 0..NUM_BLOCKS-1 show buffer[page]; page NUM_BLOCKS shows the tag.
  - A page event increments the page counter, wrapping from NUM_BLOCKS to 0.
  - A start event → CAPTURE, which starts a new session.
- ERROR: start event → CAPTURE.
- Start events in CAPTURE, LAUNCH, RUN and WAIT_TAG are ignored. Page events outside SHOW are ignored.
- `o_disp`: selected page in SHOW; all ones in ERROR; zero otherwise.
- `o_busy`=1 in CAPTURE, LAUNCH, RUN and WAIT_TAG.
- `o_done`=1 only in SHOW. `o_err`=1 only in ERROR.

## Timing
- All outputs are registered or decoded from state registers.
- Reset values: all outputs 0, FSM in IDLE, buffers 0.
- Reset asserted mid-session returns to IDLE immediately (asynchronously). `o_core_pt_valid` and `o_core_new` drop without waiting for a handshake.
- Button latency: button high is first sampled at edge n; the FSM leaves IDLE at edge n+3.
- `o_core_new` is high for exactly one cycle. The next cycle, RUN asserts `o_core_pt_valid` for block 0.
- `o_core_pt` changes only on the cycle after an accepted transfer. Valid never drops while waiting for ready.
- Tag strobe at edge t: `o_done`=1 and `o_disp` = ct block 0 from edge t+1.
- Timeout: with no transfer, ERROR is entered exactly TIMEOUT_CYC cycles after the last transfer, or after RUN entry if none has occurred.

## Test plan
- Nominal, ready always 1: sw=16'hA5_3C, core returns ct_k = {32{k}} and tag = all 5s. Expect:
  - IV = 12×A5, key = 32×C, pt_0 = 32×3, pt_1 = 32×2, AAD = ~pt_0.
  - o_disp = 16'h0000, then 1111, 2222, 3333, 5555 via four page events; a fifth event returns to 0000.
- Backpressure: ready toggles 1 of 3 cycles. Each pt index is held until accepted and no block is skipped or duplicated.
- Overlap: ct strobe in the same cycle as a pt accept, and an extra 5th ct strobe. Buffer is correct and the extra strobe is ignored.
- Error paths:
  - Tag strobe after 2 of 4 ct → o_err=1 and o_disp=FFFF.
  - Separately, a stalled core with TIMEOUT_CYC=8 → ERROR 8 cycles after the last transfer.
  - In both cases a start event then re-runs the session successfully.
- Switch change during RUN (sw → 16'hFFFF) has no effect on core outputs. Start during RUN is ignored.
- Reset deasserted-asserted mid-RUN: all outputs go to 0 at once and a later start runs cleanly.
